serial_paralelo_rx: RTL



---
 rtl/phy_rx_pkg.sv | 15 +
 rtl/serial_paralelo_rx_shift_in8.sv | 26 ++
 rtl/serial_paralelo_rx.sv | 137 +++++++++++++
 3 files changed

// File: rtl/phy_rx_pkg.sv
// Shared definitions for the PHY receive lane: idle/alignment character,
// default lock threshold and the receive FSM state type.
package phy_rx_pkg;

  localparam logic [7:0] COMMA_DEF      = 8'hBC;
  localparam int         LOCK_COUNT_DEF = 4;

  typedef enum logic [1:0] {
    RESET  = 2'd0,
    SEARCH = 2'd1,
    ALIGN  = 2'd2,
    LOCKED = 2'd3
  } rx_state_t;

endpackage

// File: rtl/serial_paralelo_rx_shift_in8.sv
// shift_in8: 8-bit MSB-first serial shift register with a comma comparator.
// clr wipes the register so a partial byte never survives a reset.
module shift_in8
  import phy_rx_pkg::*;
#(
  parameter logic [7:0] COMMA = COMMA_DEF
) (
  input  logic       clk_8f,
  input  logic       clr,
  input  logic       data_in,
  output logic [7:0] shr,
  output logic       is_comma
);

  // Shift one new bit in per cycle; the newest bit lands in bit 0.
  always_ff @(posedge clk_8f) begin
    if (clr) begin
      shr <= 8'h00;
    end else begin
      shr <= {shr[6:0], data_in};
    end
  end

  assign is_comma = (shr == COMMA);

endmodule

// File: rtl/serial_paralelo_rx.sv
// serial_paralelo_rx: per-lane receive deserializer. Finds byte alignment
// from repeated commas, locks, then delivers aligned non-comma bytes.
// Optional macro RX_BYTE_CNT_EN adds a saturating 16-bit delivered-byte
// counter on port byte_count.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   RESET  | held in reset; shift register cleared
//   SEARCH | sliding compare of every bit position against the comma
//   ALIGN  | candidate alignment; counting consecutive aligned commas
//   LOCKED | aligned; non-comma bytes delivered, left only by reset
module serial_paralelo_rx
  import phy_rx_pkg::*;
#(
  parameter logic [7:0] COMMA      = COMMA_DEF,
  parameter int         LOCK_COUNT = LOCK_COUNT_DEF
) (
  input  logic        clk_8f,
  input  logic        reset,
  input  logic        data_in,
  output logic [7:0]  data_out,
  output logic        valid_out,
  output logic        active_out
`ifdef RX_BYTE_CNT_EN
  ,
  output logic [15:0] byte_count
`endif
);

  localparam logic [3:0] LOCK_CNT4 = 4'(LOCK_COUNT);

  rx_state_t   state;
  rx_state_t   next_state;
  logic [7:0]  shr;
  logic        is_comma;
  logic [2:0]  bit_cnt;
  logic [3:0]  comma_cnt;
  logic        boundary;

  assign boundary = (bit_cnt == 3'd0);

  shift_in8 #(
    .COMMA (COMMA)
  ) u_shift (
    .clk_8f   (clk_8f),
    .clr      (reset || (state == RESET)),
    .data_in  (data_in),
    .shr      (shr),
    .is_comma (is_comma)
  );

  // State register; reset forces RESET regardless of the current state.
  always_ff @(posedge clk_8f) begin
    if (reset) begin
      state <= RESET;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decision from the aligned-byte comparisons.
  always_comb begin
    next_state = state;
    case (state)
      RESET:  next_state = SEARCH;
      SEARCH: if (is_comma) next_state = ALIGN;
      ALIGN: begin
        if (boundary) begin
          if (!is_comma) begin
            next_state = SEARCH;
          end else if ((comma_cnt + 4'd1) == LOCK_CNT4) begin
            next_state = LOCKED;
          end
        end
      end
      LOCKED: next_state = LOCKED;
      default: next_state = RESET;
    endcase
  end

  // Bit/comma counters, delivered byte, strobe and lock indication.
  always_ff @(posedge clk_8f) begin
    if (reset) begin
      bit_cnt    <= 3'd0;
      comma_cnt  <= 4'd0;
      data_out   <= 8'h00;
      valid_out  <= 1'b0;
      active_out <= 1'b0;
`ifdef RX_BYTE_CNT_EN
      byte_count <= 16'h0000;
`endif
    end else begin
      valid_out  <= 1'b0;
      active_out <= (next_state == LOCKED);
      case (state)
        RESET: begin
          bit_cnt   <= 3'd0;
          comma_cnt <= 4'd0;
        end
        SEARCH: begin
          // The matching cycle is itself a boundary, so the next one is 8 away.
          if (is_comma) begin
            bit_cnt   <= 3'd1;
            comma_cnt <= 4'd1;
          end
        end
        ALIGN: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (boundary) begin
            if (is_comma) begin
              comma_cnt <= comma_cnt + 4'd1;
            end else begin
              comma_cnt <= 4'd0;
            end
          end
        end
        LOCKED: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (boundary && !is_comma) begin
            data_out  <= shr;
            valid_out <= 1'b1;
`ifdef RX_BYTE_CNT_EN
            if (byte_count != 16'hFFFF) begin
              byte_count <= byte_count + 16'd1;
            end
`endif
          end
        end
        default: begin
          bit_cnt   <= 3'd0;
          comma_cnt <= 4'd0;
        end
      endcase
    end
  end

endmodule
